// File: rtl/xs3_to_bcd_serial_if.sv
// Stream and result bundle for the bit-serial Excess-3 to BCD decoder.
// The master drives the Excess-3 bit stream; the slave (the decoder)
// returns the decoded bit stream plus per-digit and per-word results.
interface xs3_to_bcd_serial_if #(
    parameter int NDIG = 4
);
    logic              in_valid;
    logic              in_bit;
    logic              in_sop;
    logic              bit_valid;
    logic              bit_out;
    logic              digit_valid;
    logic [3:0]        digit;
    logic              digit_err;
    logic              word_valid;
    logic [4*NDIG-1:0] word;
    logic              word_err;

    modport master (
        output in_valid, in_bit, in_sop,
        input  bit_valid, bit_out, digit_valid, digit, digit_err,
               word_valid, word, word_err
    );

    modport slave (
        input  in_valid, in_bit, in_sop,
        output bit_valid, bit_out, digit_valid, digit, digit_err,
               word_valid, word, word_err
    );
endinterface

// File: rtl/xs3_to_bcd_serial.sv
// Bit-serial Excess-3 to BCD decoder.
// Each digit arrives LSB first; 3 is subtracted serially by a borrow-tracking
// Mealy FSM whose state is {bit position, borrow}. Decoded bits come out one
// cycle later, and completed digits are packed into NDIG-digit words with
// digit 0 in the low nibble. Codes below 0011 or above 1100 are flagged.
module xs3_to_bcd_serial #(
    parameter int NDIG = 4
) (
    input logic              clk,
    input logic              rst,
    xs3_to_bcd_serial_if.slave bus
);

    localparam int         WW       = 4 * NDIG;
    localparam logic [2:0] LAST_DIG = 3'(NDIG - 1);

    // State encoding is {bitPos[1:0], borrow} so the fields can be sliced out.
    typedef enum logic [2:0] {
        S0B0 = 3'b000, S0B1 = 3'b001,
        S1B0 = 3'b010, S1B1 = 3'b011,
        S2B0 = 3'b100, S2B1 = 3'b101,
        S3B0 = 3'b110, S3B1 = 3'b111
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      shift_q, shift_d;
    logic [2:0]      digCnt_q, digCnt_d;
    logic [WW-1:0]   wordAcc_q, wordAcc_d;
    logic            errAcc_q, errAcc_d;

    logic            bitValid_q, bitValid_d;
    logic            bitOut_q, bitOut_d;
    logic            digitValid_q, digitValid_d;
    logic [3:0]      digit_q, digit_d;
    logic            digitErr_q, digitErr_d;
    logic            wordValid_q, wordValid_d;
    logic [WW-1:0]   word_q, word_d;
    logic            wordErr_q, wordErr_d;

    logic            restart;
    logic [1:0]      bitPos;
    logic            borrow;
    logic            subBit;
    logic            outBit;
    logic            borrowNext;
    logic [3:0]      digitVal;
    logic            digitBad;
    logic [2:0]      cntEff;
    logic            errEff;

    // Serial subtract-3 datapath plus digit/word assembly; a start-of-packet
    // bit restarts the digit and word from scratch before it is decoded.
    always_comb begin
        restart    = bus.in_valid & bus.in_sop;
        bitPos     = restart ? 2'd0 : state_q[2:1];
        borrow     = restart ? 1'b0 : state_q[0];
        cntEff     = restart ? 3'd0 : digCnt_q;
        errEff     = restart ? 1'b0 : errAcc_q;
        subBit     = ~bitPos[1];
        outBit     = bus.in_bit ^ subBit ^ borrow;
        borrowNext = (~bus.in_bit & (subBit | borrow)) | (subBit & borrow);
        digitVal   = {outBit, shift_q};
        digitBad   = borrowNext | (digitVal > 4'd9);

        state_d      = state_q;
        shift_d      = shift_q;
        digCnt_d     = digCnt_q;
        wordAcc_d    = wordAcc_q;
        errAcc_d     = errAcc_q;
        bitValid_d   = 1'b0;
        bitOut_d     = bitOut_q;
        digitValid_d = 1'b0;
        digit_d      = digit_q;
        digitErr_d   = digitErr_q;
        wordValid_d  = 1'b0;
        word_d       = word_q;
        wordErr_d    = wordErr_q;

        if (bus.in_valid) begin
            bitValid_d = 1'b1;
            bitOut_d   = outBit;
            digCnt_d   = cntEff;
            errAcc_d   = errEff;
            if (bitPos == 2'd3) begin
                state_d      = S0B0;
                digitValid_d = 1'b1;
                digit_d      = digitVal;
                digitErr_d   = digitBad;
                for (int i = 0; i < NDIG; i++) begin
                    if (cntEff == 3'(i)) begin
                        wordAcc_d[i*4 +: 4] = digitVal;
                    end
                end
                if (cntEff == LAST_DIG) begin
                    wordValid_d = 1'b1;
                    word_d      = wordAcc_d;
                    wordErr_d   = errEff | digitBad;
                    digCnt_d    = 3'd0;
                    errAcc_d    = 1'b0;
                end else begin
                    digCnt_d = cntEff + 3'd1;
                    errAcc_d = errEff | digitBad;
                end
            end else begin
                state_d         = state_t'({bitPos + 2'd1, borrowNext});
                shift_d[bitPos] = outBit;
            end
        end
    end

    // State, accumulators and registered outputs; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S0B0;
            shift_q      <= '0;
            digCnt_q     <= '0;
            wordAcc_q    <= '0;
            errAcc_q     <= 1'b0;
            bitValid_q   <= 1'b0;
            bitOut_q     <= 1'b0;
            digitValid_q <= 1'b0;
            digit_q      <= '0;
            digitErr_q   <= 1'b0;
            wordValid_q  <= 1'b0;
            word_q       <= '0;
            wordErr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            digCnt_q     <= digCnt_d;
            wordAcc_q    <= wordAcc_d;
            errAcc_q     <= errAcc_d;
            bitValid_q   <= bitValid_d;
            bitOut_q     <= bitOut_d;
            digitValid_q <= digitValid_d;
            digit_q      <= digit_d;
            digitErr_q   <= digitErr_d;
            wordValid_q  <= wordValid_d;
            word_q       <= word_d;
            wordErr_q    <= wordErr_d;
        end
    end

    assign bus.bit_valid   = bitValid_q;
    assign bus.bit_out     = bitOut_q;
    assign bus.digit_valid = digitValid_q;
    assign bus.digit       = digit_q;
    assign bus.digit_err   = digitErr_q;
    assign bus.word_valid  = wordValid_q;
    assign bus.word        = word_q;
    assign bus.word_err    = wordErr_q;

endmodule

// File: tb/tb_xs3_to_bcd_serial.sv
// Directed bench for the serial Excess-3 decoder. The same input stream feeds
// three decoders built for 1-, 2- and 4-digit words so word assembly can be
// observed at each size while digit decoding is checked once.
module tb_xs3_to_bcd_serial;

    logic clk = 1'b0;
    logic rst;
    logic inValid;
    logic inBit;
    logic inSop;

    int total = 0;
    int bad   = 0;

    logic [3:0] obsOut;
    int         wordPulses4;
    int         spuriousDigit4;
    int         idleValidSeen;
    int         missedValid;

    xs3_to_bcd_serial_if #(.NDIG(1)) bus1 ();
    xs3_to_bcd_serial_if #(.NDIG(2)) bus2 ();
    xs3_to_bcd_serial_if #(.NDIG(4)) bus4 ();

    assign bus1.in_valid = inValid;
    assign bus1.in_bit   = inBit;
    assign bus1.in_sop   = inSop;
    assign bus2.in_valid = inValid;
    assign bus2.in_bit   = inBit;
    assign bus2.in_sop   = inSop;
    assign bus4.in_valid = inValid;
    assign bus4.in_bit   = inBit;
    assign bus4.in_sop   = inSop;

    xs3_to_bcd_serial #(.NDIG(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    xs3_to_bcd_serial #(.NDIG(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    xs3_to_bcd_serial #(.NDIG(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Drive one input cycle at the falling edge, then return 1 ns after the
    // rising edge that captured it so the registered response can be sampled.
    task automatic applyStimulus(input logic v, input logic b, input logic s);
        @(negedge clk);
        inValid = v;
        inBit   = b;
        inSop   = s;
        @(posedge clk);
        #1;
    endtask

    // Send one Excess-3 digit LSB first with optional random idle gaps,
    // recording the decoded bits and any pulse/valid anomalies.
    task automatic runDigit(input logic [3:0] code, input logic sop, input int maxGap);
        int gaps;
        for (int i = 0; i < 4; i++) begin
            gaps = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                applyStimulus(1'b0, 1'b0, 1'b0);
                if (bus4.bit_valid !== 1'b0) idleValidSeen++;
                if (bus4.word_valid === 1'b1) wordPulses4++;
            end
            applyStimulus(1'b1, code[i], sop && (i == 0));
            obsOut[i] = bus4.bit_out;
            if (bus4.bit_valid !== 1'b1) missedValid++;
            if (i < 3 && bus4.digit_valid !== 1'b0) spuriousDigit4++;
            if (bus4.word_valid === 1'b1) wordPulses4++;
            inValid = 1'b0;
            inSop   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b0; inBit = 1'b0; inSop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus4.bit_valid, bus4.bit_out, bus4.digit_valid, bus4.digit, bus4.digit_err,
             bus4.word_valid, bus4.word, bus4.word_err} !== '0) begin
            bad++;
            $display("[TB] FAIL reset.dut4: got word=%h digit=%h flags=%b expected all zero",
                     bus4.word, bus4.digit, {bus4.bit_valid, bus4.digit_valid, bus4.word_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        total++;
        if ({bus1.bit_valid, bus1.bit_out, bus1.digit_valid, bus1.digit, bus1.digit_err,
             bus1.word_valid, bus1.word, bus1.word_err} !== '0) begin
            bad++;
            $display("[TB] FAIL reset.dut1_idle: got word=%h digit=%h expected all zero",
                     bus1.word, bus1.digit);
        end
    endtask

    task automatic test_digits();
        logic [3:0] codes[5]  = '{4'b0011, 4'b1100, 4'b0111, 4'b0001, 4'b1101};
        logic [3:0] expDig[5] = '{4'h0,    4'h9,    4'h4,    4'hE,    4'hA};
        logic       expErr[5] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b1};
        spuriousDigit4 = 0;
        for (int d = 0; d < 5; d++) begin
            runDigit(codes[d], d == 0, 0);
            total++;
            if (obsOut !== expDig[d]) begin
                bad++;
                $display("[TB] FAIL digits.bits[%0d]: got %b expected %b", d, obsOut, expDig[d]);
            end
            total++;
            if (bus1.digit_valid !== 1'b1 || bus1.digit !== expDig[d] || bus1.digit_err !== expErr[d]) begin
                bad++;
                $display("[TB] FAIL digits.digit[%0d]: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                         d, bus1.digit_valid, bus1.digit, bus1.digit_err, expDig[d], expErr[d]);
            end
            total++;
            if (bus1.word_valid !== 1'b1 || bus1.word !== expDig[d] || bus1.word_err !== expErr[d]) begin
                bad++;
                $display("[TB] FAIL digits.word1[%0d]: got v=%b w=%h e=%b expected v=1 w=%h e=%b",
                         d, bus1.word_valid, bus1.word, bus1.word_err, expDig[d], expErr[d]);
            end
        end
        total++;
        if (spuriousDigit4 !== 0) begin
            bad++;
            $display("[TB] FAIL digits.early_pulse: got %0d expected 0", spuriousDigit4);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        total++;
        if (bus1.digit_valid !== 1'b0 || bus1.word_valid !== 1'b0 || bus1.bit_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL digits.pulse_drop: got dv=%b wv=%b bv=%b expected 0 0 0",
                     bus1.digit_valid, bus1.word_valid, bus1.bit_valid);
        end
        total++;
        if (bus1.digit !== 4'hA || bus1.digit_err !== 1'b1 || bus1.word !== 4'hA) begin
            bad++;
            $display("[TB] FAIL digits.hold: got d=%h e=%b w=%h expected d=a e=1 w=a",
                     bus1.digit, bus1.digit_err, bus1.word);
        end
    endtask

    task automatic test_word_err();
        runDigit(4'b0101, 1'b1, 0);
        total++;
        if (bus2.word_valid !== 1'b0 || bus2.digit !== 4'h2) begin
            bad++;
            $display("[TB] FAIL word_err.first: got wv=%b d=%h expected wv=0 d=2",
                     bus2.word_valid, bus2.digit);
        end
        runDigit(4'b0000, 1'b0, 0);
        total++;
        if (bus2.word_valid !== 1'b1 || bus2.word !== 8'hD2 || bus2.word_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL word_err.bad_word: got v=%b w=%h e=%b expected v=1 w=d2 e=1",
                     bus2.word_valid, bus2.word, bus2.word_err);
        end
        runDigit(4'b0100, 1'b1, 0);
        runDigit(4'b0101, 1'b0, 0);
        total++;
        if (bus2.word_valid !== 1'b1 || bus2.word !== 8'h21 || bus2.word_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL word_err.clean_word: got v=%b w=%h e=%b expected v=1 w=21 e=0",
                     bus2.word_valid, bus2.word, bus2.word_err);
        end
    endtask

    task automatic test_gaps();
        logic [3:0] codes[4]  = '{4'b0111, 4'b0110, 4'b0101, 4'b0100};
        logic [3:0] expDig[4] = '{4'h4,    4'h3,    4'h2,    4'h1};
        wordPulses4 = 0; idleValidSeen = 0; missedValid = 0;
        for (int d = 0; d < 4; d++) begin
            runDigit(codes[d], d == 0, 3);
            total++;
            if (obsOut !== expDig[d] || bus4.digit !== expDig[d]) begin
                bad++;
                $display("[TB] FAIL gaps.digit[%0d]: got bits=%b d=%h expected %h",
                         d, obsOut, bus4.digit, expDig[d]);
            end
        end
        total++;
        if (wordPulses4 !== 1 || bus4.word_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL gaps.word_pulses: got count=%0d last=%b expected 1 1",
                     wordPulses4, bus4.word_valid);
        end
        total++;
        if (bus4.word !== 16'h1234 || bus4.word_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL gaps.word: got %h e=%b expected 1234 e=0", bus4.word, bus4.word_err);
        end
        total++;
        if (idleValidSeen !== 0 || missedValid !== 0) begin
            bad++;
            $display("[TB] FAIL gaps.bit_valid: got idle_hi=%0d missed=%0d expected 0 0",
                     idleValidSeen, missedValid);
        end
    endtask

    task automatic test_sop_abort();
        wordPulses4 = 0;
        runDigit(4'b0111, 1'b1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        inValid = 1'b0;
        runDigit(4'b1011, 1'b1, 0);
        total++;
        if (bus4.digit !== 4'h8 || bus4.word_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sop_abort.first_digit: got d=%h wv=%b expected 8 0",
                     bus4.digit, bus4.word_valid);
        end
        runDigit(4'b1010, 1'b0, 0);
        runDigit(4'b1001, 1'b0, 0);
        runDigit(4'b1000, 1'b0, 0);
        total++;
        if (wordPulses4 !== 1 || bus4.word_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sop_abort.pulses: got count=%0d last=%b expected 1 1",
                     wordPulses4, bus4.word_valid);
        end
        total++;
        if (bus4.word !== 16'h5678 || bus4.word_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL sop_abort.word: got %h e=%b expected 5678 e=0", bus4.word, bus4.word_err);
        end
    endtask

    task automatic test_async_reset();
        runDigit(4'b1100, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        total++;
        if (bus4.bit_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL async_reset.pre: got bit_valid=%b expected 1", bus4.bit_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus4.bit_valid, bus4.bit_out, bus4.digit_valid, bus4.digit, bus4.digit_err,
             bus4.word_valid, bus4.word, bus4.word_err} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset.dut4: got word=%h digit=%h bv=%b expected all zero",
                     bus4.word, bus4.digit, bus4.bit_valid);
        end
        total++;
        if ({bus1.digit, bus1.word, bus2.word} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset.others: got w1=%h w2=%h expected zero", bus1.word, bus2.word);
        end
        inValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wordPulses4 = 0;
        runDigit(4'b1100, 1'b1, 0);
        runDigit(4'b0011, 1'b0, 0);
        runDigit(4'b0100, 1'b0, 0);
        runDigit(4'b0101, 1'b0, 0);
        total++;
        if (wordPulses4 !== 1 || bus4.word !== 16'h2109 || bus4.word_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset.after: got count=%0d w=%h e=%b expected 1 2109 0",
                     wordPulses4, bus4.word, bus4.word_err);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting xs3_to_bcd_serial bench");
        test_reset();
        test_digits();
        test_word_err();
        test_gaps();
        test_sop_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
